gpio_in_monitor: RTL and testbench
==================================

# gpio_in_monitor

Parametrised N-channel input conditioner for the application FPGA's discrete status inputs: limit switches, fuse-OK, water/flow faults and loop-state lines. Each channel is synchronised, debounced, and edge-detected. Each channel also carries a sticky change flag, which software clears per bit. The block sits between the board I/O and the control/register logic, and its aggregated `all_high` and `irq` outputs replace the flat one-register-and-AND input check.

## Interface
Parameters:
- `NUM_CH`, 88: number of monitored input channels.
- `SYNC_STAGES`, 2: synchroniser flops per channel, ≥2.
- `DEBOUNCE_CYCLES`, 1000: consecutive cycles a new level must persist before it is accepted (10 µs at 100 MHz), ≥1.
- `RST_VAL`, `{NUM_CH{1'b0}}`: per-channel reset level for the synchroniser and `stable`.

Ports (one clock; reset is asynchronous and active-high):
- `CLK_100M`  in  1  system clock, 100 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  NUM_CH  raw asynchronous pad inputs.
- `ch_en`  in  NUM_CH  per-channel enable, quasi-static.
- `clr_sticky`  in  NUM_CH  write-1-to-clear pulse for the sticky flags.
- `stable`  out  NUM_CH  debounced level.
- `rise_pulse`  out  NUM_CH  one-cycle pulse on a debounced 0→1 transition.
- `fall_pulse`  out  NUM_CH  one-cycle pulse on a debounced 1→0 transition.
- `sticky`  out  NUM_CH  latched "level changed since last clear".
- `all_high`  out  1  AND of `stable` over enabled channels; disabled channels count as 1.
- `irq`  out  1  OR of `sticky`.

## Operation
Reset values:
- Synchroniser flops and `stable` reset to `RST_VAL`.
- The debounce counter resets to 0.
- `rise_pulse`, `fall_pulse`, `sticky` and `irq` reset to 0.
- `all_high` resets to 0.

Per channel, with `s` = the synchroniser output:
- Counter behaviour:
  - If `s == stable`: counter ← 0.
  - Else if counter == DEBOUNCE_CYCLES−1: `stable` ← `s`, counter ← 0, and the matching pulse is asserted.
  - Else: counter ← counter+1.
- A glitch shorter than DEBOUNCE_CYCLES cycles at `s` produces no change and resets the counter.
- Counter width is `$clog2(DEBOUNCE_CYCLES+1)`. The counter never wraps.
- `rise_pulse`/`fall_pulse` are registered. They assert on the same edge that `stable` changes and deassert on the next edge.

Sticky flag:
- Sets on the edge where `stable` changes.
- Clears on the edge after a `clr_sticky` bit is seen.
- Simultaneous set and clear: set wins.

Disabled channel (`ch_en=0`):
- Counter is held at 0, `stable` is frozen, pulses are 0, and `sticky` is forced to 0.
- The synchroniser keeps running.
- On re-enable, debounce restarts from a counter value of 0.

Aggregates:
- `all_high` is registered from `stable` and `ch_en`, and lags `stable` by one cycle.
- `irq` is registered from `sticky`, and lags it by one cycle.

Reset asserted mid-debounce discards the count. After release, no pulse fires unless `din` differs from `RST_VAL` for DEBOUNCE_CYCLES cycles.

## Timing
- `din` step → `s` change: SYNC_STAGES edges.
- `s` change held → `stable`, pulse and `sticky`: DEBOUNCE_CYCLES edges later.
- Total `din` → `stable` latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- `din` → `irq` and `din` → `all_high` latency: SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
- `clr_sticky` → `sticky` low: 1 cycle. `clr_sticky` → `irq` low: 2 cycles, if no other flag is set.
- With DEBOUNCE_CYCLES=1, `stable` follows `s` with one cycle of delay.
- There are no multicycle paths, and all outputs are registered.

## Structure
- Shared include `gpio_mon_defs.vh` holds:
  - default DEBOUNCE_CYCLES for 100 MHz;
  - the channel-index constants for the board signal map (e.g. CW_LIMIT_STAT, WATER_LOW_ERROR bit positions) used by the top level.
- Sub-module `gpio_debounce_ch`: one channel (synchroniser, counter, stable, pulses, sticky). It is instantiated NUM_CH times in a generate loop.
- The top of `gpio_in_monitor` holds only the generate loop and the `all_high`/`irq` reduction registers.

## Test plan
Bench uses NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RST_VAL=4'b0000, and all channels enabled unless stated.

- **Clean rise:** set `din[0]` 0→1 and hold.
  - `stable[0]` and `rise_pulse[0]` rise exactly 6 cycles after the first sampling edge.
  - The pulse is 1 cycle wide.
  - `sticky[0]`=1 on the same edge; `irq`=1 one cycle later.
- **Glitch reject:** drive `din[1]` high for 3 cycles, then low.
  - `stable[1]` stays 0, with no pulse, no sticky and no `irq`.
  - A 4-cycle high pulse is accepted and is followed by a `fall_pulse` when it returns low.
- **Clear race:** assert `clr_sticky[0]` on the same edge that a `fall_pulse[0]` sets sticky.
  - `sticky[0]` remains 1.
  - A later isolated clear drops `sticky[0]` in 1 cycle and `irq` in 2.
- **all_high and disable:** drive `din`=4'b0111 with `ch_en`=4'b0111.
  - `all_high`=1.
  - Setting `ch_en[3]`=1 gives `all_high`=0 one cycle later.
  - A disabled channel toggling `din` never pulses or sets sticky.
- **Reset mid-debounce:** pulse `rst` while the `din[2]` counter is at 2, with `din[2]` held high.
  - All outputs return to their reset values.
  - After release, `rise_pulse[2]` fires 6 cycles later.
- **Reset value:** with RST_VAL=4'b1111 and `din`=4'b1111 at release, no pulses fire and `sticky`=0 for 20 cycles.

Source files
------------

// File: rtl/gpio_in_monitor_pkg.sv
// Shared constants for the discrete-input monitor: the default debounce length
// for a 100 MHz clock and the board signal map for the channel indices.
package gpio_in_monitor_pkg;

  localparam int DEBOUNCE_100M = 1000;  // 10 us at 100 MHz
  localparam int SYNC_DEFAULT  = 2;

  typedef enum int {
    CH_CW_LIMIT_STAT   = 0,
    CH_CCW_LIMIT_STAT  = 1,
    CH_FUSE_OK         = 2,
    CH_WATER_LOW_ERROR = 3,
    CH_FLOW_ERROR      = 4,
    CH_LOOP_STATE      = 5
  } ch_idx_e;

  // The counter must be able to hold DEBOUNCE_CYCLES-1 without wrapping.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpio_in_monitor_debounce_ch.sv
// One input channel: synchroniser, debounce counter, debounced level,
// registered edge pulses and a software-clearable sticky change flag.
module gpio_debounce_ch
  import gpio_in_monitor_pkg::*;
#(
  parameter int   SYNC_STAGES     = SYNC_DEFAULT,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_100M,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic en,
  input  logic clr_sticky,
  output logic stable,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic sticky
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   s;
  logic                   accept;

  // The synchroniser runs even when the channel is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      // NOTE: non-blocking keeps every stage sampling the previous cycle's value, so this is a true shift chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign accept = en && (s != stable) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      stable     <= RST_VAL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      sticky     <= 1'b0;
    end else begin
      rise_pulse <= accept && s;
      fall_pulse <= accept && !s;

      if (!en || (s == stable) || accept) cnt <= '0;
      else                                cnt <= cnt + 1'b1;

      if (accept) stable <= s;

      // A new change outranks a clear arriving on the same edge.
      if (!en)             sticky <= 1'b0;
      else if (accept)     sticky <= 1'b1;
      else if (clr_sticky) sticky <= 1'b0;
    end
  end

endmodule

// File: rtl/gpio_in_monitor.sv
// N-channel discrete input conditioner: one debounce channel per input plus
// the registered all-enabled-high check and sticky-flag interrupt.
module gpio_in_monitor
  import gpio_in_monitor_pkg::*;
#(
  parameter int                NUM_CH          = 88,
  parameter int                SYNC_STAGES     = SYNC_DEFAULT,
  parameter int                DEBOUNCE_CYCLES = DEBOUNCE_100M,
  parameter logic [NUM_CH-1:0] RST_VAL         = {NUM_CH{1'b0}}
) (
  input  logic              CLK_100M,
  input  logic              rst,
  input  logic [NUM_CH-1:0] din,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] clr_sticky,
  output logic [NUM_CH-1:0] stable,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] sticky,
  output logic              all_high,
  output logic              irq
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gpio_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RST_VAL        (RST_VAL[i])
    ) u_ch (
      .clk       (CLK_100M),
      .rst       (rst),
      .din       (din[i]),
      .en        (ch_en[i]),
      .clr_sticky(clr_sticky[i]),
      .stable    (stable[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i]),
      .sticky    (sticky[i])
    );
  end

  // Disabled channels read as high so they never block the AND.
  always_ff @(posedge CLK_100M or posedge rst) begin
    if (rst) begin
      all_high <= 1'b0;
      irq      <= 1'b0;
    end else begin
      all_high <= &(stable | ~ch_en);
      irq      <= |sticky;
    end
  end

endmodule

// File: tb/tb_gpio_in_monitor.sv
// Directed bench for gpio_in_monitor: 4 channels, 2 sync stages, debounce of 4,
// plus a second instance with an all-ones reset level.
module tb_gpio_in_monitor;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] din, ch_en, clr_sticky;
  logic [NCH-1:0] stable, rise_pulse, fall_pulse, sticky;
  logic           all_high, irq;

  logic [NCH-1:0] din_hi;
  logic [NCH-1:0] stable_hi, rise_hi, fall_hi, sticky_hi;
  logic           all_high_hi, irq_hi;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpio_in_monitor #(
    .NUM_CH(NCH), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RST_VAL(4'b0000)
  ) u_dut (
    .CLK_100M(clk), .rst(rst), .din(din), .ch_en(ch_en), .clr_sticky(clr_sticky),
    .stable(stable), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .sticky(sticky), .all_high(all_high), .irq(irq)
  );

  gpio_in_monitor #(
    .NUM_CH(NCH), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RST_VAL(4'b1111)
  ) u_dut_hi (
    .CLK_100M(clk), .rst(rst), .din(din_hi), .ch_en(4'b1111), .clr_sticky(4'b0000),
    .stable(stable_hi), .rise_pulse(rise_hi), .fall_pulse(fall_hi),
    .sticky(sticky_hi), .all_high(all_high_hi), .irq(irq_hi)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_all();
    clr_sticky = 4'hF;
    step(1);
    clr_sticky = 4'h0;
    step(2);
  endtask

  logic [NCH-1:0] seen;

  initial begin
    rst = 1'b1; din = '0; ch_en = 4'hF; clr_sticky = '0; din_hi = 4'hF;
    step(3);
    check("rst_stable", stable, 4'h0);
    check("rst_pulses", {rise_pulse, fall_pulse}, 8'h00);
    check("rst_sticky", sticky, 4'h0);
    check("rst_irq_allhigh", {irq, all_high}, 2'b00);
    rst = 1'b0;
    step(3);

    // Clean rise on channel 0
    din[0] = 1'b1;
    step(5);
    check("rise_early_stable", stable[0], 1'b0);
    step(1);
    check("rise_stable", stable[0], 1'b1);
    check("rise_pulse", rise_pulse[0], 1'b1);
    check("rise_sticky", sticky[0], 1'b1);
    check("rise_irq_lag", irq, 1'b0);
    step(1);
    check("rise_pulse_width", rise_pulse[0], 1'b0);
    check("rise_irq", irq, 1'b1);
    clr_sticky[0] = 1'b1;
    step(1);
    clr_sticky[0] = 1'b0;
    check("clr_sticky_1cyc", sticky[0], 1'b0);
    check("clr_irq_still", irq, 1'b1);
    step(1);
    check("clr_irq_2cyc", irq, 1'b0);

    // Glitch of 3 cycles on channel 1 is rejected
    seen = '0;
    din[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin step(1); seen |= rise_pulse | fall_pulse | sticky; end
    din[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin step(1); seen |= rise_pulse | fall_pulse | sticky; end
    check("glitch_stable", stable[1], 1'b0);
    check("glitch_no_activity", seen[1], 1'b0);
    check("glitch_irq", irq, 1'b0);

    // Four-cycle pulse is accepted, then falls
    din[1] = 1'b1;
    step(4);
    din[1] = 1'b0;
    step(2);
    check("pulse4_rise", {stable[1], rise_pulse[1]}, 2'b11);
    step(4);
    check("pulse4_fall", {stable[1], fall_pulse[1]}, 2'b01);
    clear_all();

    // Clear races with the fall of channel 0: set wins
    din[0] = 1'b0;
    step(5);
    clr_sticky[0] = 1'b1;
    step(1);
    clr_sticky[0] = 1'b0;
    check("race_fall_pulse", fall_pulse[0], 1'b1);
    check("race_sticky_kept", sticky[0], 1'b1);
    step(1);
    check("race_sticky_hold", sticky[0], 1'b1);
    check("race_irq", irq, 1'b1);
    clr_sticky[0] = 1'b1;
    step(1);
    clr_sticky[0] = 1'b0;
    check("race_clr_sticky", sticky[0], 1'b0);
    check("race_clr_irq_lag", irq, 1'b1);
    step(1);
    check("race_clr_irq", irq, 1'b0);

    // all_high with channel 3 disabled, then enabled
    din = 4'b0111; ch_en = 4'b0111;
    step(8);
    check("allhigh_stable", stable, 4'b0111);
    check("allhigh_masked", all_high, 1'b1);
    clear_all();
    ch_en[3] = 1'b1;
    step(1);
    check("allhigh_enabled", all_high, 1'b0);
    ch_en[3] = 1'b0;
    seen = '0;
    din[3] = 1'b1;
    for (int i = 0; i < 8; i++) begin step(1); seen |= rise_pulse | fall_pulse | sticky; end
    din[3] = 1'b0;
    for (int i = 0; i < 8; i++) begin step(1); seen |= rise_pulse | fall_pulse | sticky; end
    check("disabled_no_activity", seen[3], 1'b0);
    check("disabled_frozen", stable[3], 1'b0);
    check("disabled_allhigh", all_high, 1'b1);

    // Reset in the middle of a debounce on channel 2
    ch_en = 4'hF; din = 4'h0;
    step(10);
    clear_all();
    din[2] = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    check("midrst_stable", stable, 4'h0);
    check("midrst_pulses", {rise_pulse, fall_pulse}, 8'h00);
    check("midrst_sticky", sticky, 4'h0);
    check("midrst_irq_allhigh", {irq, all_high}, 2'b00);
    rst = 1'b0;
    step(5);
    check("midrst_no_early", rise_pulse[2], 1'b0);
    step(1);
    check("midrst_rise", rise_pulse[2], 1'b1);

    // All-ones reset level with all-ones input: nothing happens
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    seen = '0;
    for (int i = 0; i < 20; i++) begin step(1); seen |= rise_hi | fall_hi | sticky_hi; end
    check("rstval_no_activity", seen, 4'h0);
    check("rstval_stable", stable_hi, 4'hF);
    check("rstval_allhigh_irq", {all_high_hi, irq_hi}, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
